fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter INIT_PC, default 4'h0, the PC value loaded at reset and on restart.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  one-cycle pulse that begins execution from IDLE or HALT.
REQ-005 The block SHALL have port stall  input  1  while high, hold state, PC, IR and decode outputs.
REQ-006 The block SHALL have port load_en  input  1  program-memory write strobe.
REQ-007 The block SHALL have port load_addr  input  4  program-memory write address.
REQ-008 The block SHALL have port load_data  input  8  program-memory write data.
REQ-009 The block SHALL have port next_pc  input  4  next-PC value from the downstream next-PC logic.
REQ-010 The block SHALL have port pc  output  4  current program counter, registered.
REQ-011 The block SHALL have port add  output  1  decoded ADD, registered.
REQ-012 The block SHALL have port li  output  1  decoded LI, registered.
REQ-013 The block SHALL have port addr  output  4  instruction field IR[3:0], registered.
REQ-014 The block SHALL have port instr  output  8  instruction register IR.
REQ-015 The block SHALL have port busy  output  1  high in FETCH, DECODE and EXEC.
REQ-016 The block SHALL have port halted  output  1  high in HALT.

Function
REQ-017 Program memory SHALL be 16 x 8 bits, written synchronously when load_en=1 and state is IDLE or HALT, and ignored otherwise.
REQ-018 Opcode IR[7:6] SHALL decode as 00 ADD, 01 LI, 10 BR (add=li=0), 11 HLT.
REQ-019 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC and HALT.
REQ-020 IDLE SHALL go to FETCH on start; HALT SHALL go to FETCH on start and load pc<=INIT_PC.
REQ-021 In FETCH the block SHALL set IR<=mem[pc] and go to DECODE.
REQ-022 In DECODE the block SHALL register add, li and addr from IR, then go to HALT if opcode=HLT, else to EXEC.
REQ-023 In EXEC the block SHALL set pc<=next_pc and go to FETCH.
REQ-024 Instruction latency SHALL be exactly 3 cycles (FETCH, DECODE, EXEC) with stall=0.
REQ-025 When stall=1 in any busy state, all registers SHALL hold; stall SHALL be ignored in IDLE and HALT.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 A load_en write in the same cycle as start SHALL complete the write, and the fetch SHALL see the new data only if the write occurred before the FETCH cycle.
REQ-028 The block SHALL NOT modify next_pc; PC wrap 4'hF->4'h0 SHALL be taken as supplied by next_pc.
REQ-029 In HALT the block SHALL leave pc unchanged, so pc is the HLT instruction's address.
REQ-030 add, li and addr SHALL hold their last decoded values between DECODE cycles.

Reset
REQ-031 When rst_n=0 the block SHALL asynchronously set state=IDLE, pc=INIT_PC, IR=8'h00, add=0, li=0, addr=0, busy=0 and halted=0.
REQ-032 Reset mid-instruction SHALL abort the instruction without a PC update.
REQ-033 Program memory SHALL NOT be reset.
REQ-034 Release of rst_n SHALL be treated synchronously, and the first start SHALL be accepted on the first rising edge after release.

Structure
REQ-035 A shared package SHALL hold the opcode constants (OP_ADD, OP_LI, OP_BR, OP_HLT) and the FSM state encoding.
REQ-036 Program memory SHALL be one sub-module, prog_mem_16x8, with synchronous write and combinational read.

Verification
REQ-037 The bench SHALL cover: load mem[0]=8'h05 (ADD), next_pc tied to pc+1, start -> add=1 and addr=4'h5 after DECODE, pc=1 after EXEC, busy high 3 cycles.
REQ-038 The bench SHALL cover: mem[1]=8'hC0 (HLT) -> halted=1 and pc=1 held; then start -> pc=INIT_PC and FETCH next cycle.
REQ-039 The bench SHALL cover: stall=1 for 4 cycles during DECODE -> state, pc and IR unchanged; resumes with total latency 7 cycles.
REQ-040 The bench SHALL cover: load_en during EXEC to address 2 -> mem[2] unchanged on later readback.
REQ-041 The bench SHALL cover: rst_n=0 asserted mid-EXEC with next_pc=4'hA -> pc=INIT_PC immediately, IDLE, busy=0.
REQ-042 The bench SHALL cover: BR 8'h8F with next_pc=4'hF, then next_pc=4'h0 -> pc wraps 4'hF->4'h0 with no error.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the
// fetch sequencer.
package fetch_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LI  = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Opcode lives in the top two bits of the instruction word.
  function automatic logic [1:0] opcode_of(input logic [7:0] ir);
    return ir[7:6];
  endfunction

  // Returns {add, li} for an opcode; BR and HLT raise neither flag.
  function automatic logic [1:0] decode_flags(input logic [1:0] op);
    logic [1:0] flags;
    flags = 2'b00;
    case (op)
      OP_ADD:        flags = 2'b10;
      OP_LI:         flags = 2'b01;
      OP_BR, OP_HLT: flags = 2'b00;
      default:       flags = 2'b00;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/prog_mem_16x8.sv
// 16 x 8 program memory: synchronous write, combinational read, no reset
// (contents survive a sequencer reset).
module prog_mem_16x8 (
  input  logic       clk,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [16];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: walks IDLE -> FETCH -> DECODE -> EXEC
// until an HLT instruction parks it in HALT. The next PC is supplied from
// outside and taken verbatim.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [3:0] INIT_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic       load_en,
  input  logic [3:0] load_addr,
  input  logic [7:0] load_data,
  input  logic [3:0] next_pc,
  output logic [3:0] pc,
  output logic       add,
  output logic       li,
  output logic [3:0] addr,
  output logic [7:0] instr,
  output logic       busy,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       add_q, add_d;
  logic       li_q, li_d;
  logic [3:0] addr_q, addr_d;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic [1:0] flags;

  // Memory is only writable while the sequencer is not running.
  assign mem_we = load_en && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  prog_mem_16x8 u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  assign flags = decode_flags(opcode_of(ir_q));

  // Next-state and datapath-update logic; stall freezes every busy state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    add_d   = add_q;
    li_d    = li_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = INIT_PC;
        end
      end
      ST_FETCH: begin
        if (!stall) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          add_d   = flags[1];
          li_d    = flags[0];
          addr_d  = ir_q[3:0];
          state_d = (opcode_of(ir_q) == OP_HLT) ? ST_HALT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= INIT_PC;
      ir_q    <= 8'h00;
      add_q   <= 1'b0;
      li_q    <= 1'b0;
      addr_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      add_q   <= add_d;
      li_q    <= li_d;
      addr_q  <= addr_d;
    end
  end

  assign pc     = pc_q;
  assign add    = add_q;
  assign li     = li_q;
  assign addr   = addr_q;
  assign instr  = ir_q;
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program scenarios, an instruction-level
// reference model checked every cycle, and literal spot checks.
module tb_fetch_sequencer;

  localparam logic [3:0] INIT_PC = 4'h0;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [3:0] next_pc;
  logic [3:0] pc;
  logic       add;
  logic       li;
  logic [3:0] addr;
  logic [7:0] instr;
  logic       busy;
  logic       halted;

  int vectors;
  int miscompares;

  fetch_sequencer #(.INIT_PC(INIT_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .next_pc   (next_pc),
    .pc        (pc),
    .add       (add),
    .li        (li),
    .addr      (addr),
    .instr     (instr),
    .busy      (busy),
    .halted    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks which of the three instruction cycles is in
  // progress, plus the architectural PC/IR/decode values and memory image.
  logic [7:0] m_mem [16];
  logic       m_run;
  logic       m_halt;
  int         m_step;
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  logic       m_add;
  logic       m_li;
  logic [3:0] m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_halt <= 1'b0;
      m_step <= 0;
      m_pc   <= INIT_PC;
      m_ir   <= 8'h00;
      m_add  <= 1'b0;
      m_li   <= 1'b0;
      m_addr <= 4'h0;
    end else if (!m_run) begin
      if (load_en) m_mem[load_addr] <= load_data;
      if (start) begin
        m_run  <= 1'b1;
        m_step <= 0;
        m_halt <= 1'b0;
        if (m_halt) m_pc <= INIT_PC;
      end
    end else if (!stall) begin
      if (m_step == 0) begin
        m_ir   <= m_mem[m_pc];
        m_step <= 1;
      end else if (m_step == 1) begin
        m_add  <= (m_ir[7:6] == 2'd0);
        m_li   <= (m_ir[7:6] == 2'd1);
        m_addr <= m_ir[3:0];
        if (m_ir[7:6] == 2'd3) begin
          m_run  <= 1'b0;
          m_halt <= 1'b1;
        end else begin
          m_step <= 2;
        end
      end else begin
        m_pc   <= next_pc;
        m_step <= 0;
      end
    end
  end

  // Every cycle out of reset, all outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_pc", int'(pc), int'(m_pc));
      chk("model_instr", int'(instr), int'(m_ir));
      chk("model_add", int'(add), int'(m_add));
      chk("model_li", int'(li), int'(m_li));
      chk("model_addr", int'(addr), int'(m_addr));
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_halted", int'(halted), int'(m_halt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prog [16];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    load_en   = 1'b0;
    load_addr = 4'h0;
    load_data = 8'h00;
    next_pc   = 4'h0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h80 | 8'(i);
    prog[0]  = 8'h05;  // ADD 5
    prog[1]  = 8'hC0;  // HLT
    prog[2]  = 8'h4A;  // LI 0xA
    prog[3]  = 8'h8F;  // BR 0xF
    prog[15] = 8'h8F;  // BR 0xF

    // Reset values
    repeat (2) tick();
    chk("rst_pc", int'(pc), int'(INIT_PC));
    chk("rst_instr", int'(instr), 0);
    chk("rst_add", int'(add), 0);
    chk("rst_li", int'(li), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    rst_n = 1'b1;

    // Program load while idle
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 4'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;

    // ADD at 0 with next_pc = pc+1, then HLT at 1
    next_pc = 4'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_fetch_busy", int'(busy), 1);
    chk("add_fetch_pc", int'(pc), 0);
    tick();
    chk("add_dec_instr", int'(instr), 8'h05);
    chk("add_dec_busy", int'(busy), 1);
    tick();
    chk("add_exec_add", int'(add), 1);
    chk("add_exec_addr", int'(addr), 5);
    chk("add_exec_li", int'(li), 0);
    chk("add_exec_busy", int'(busy), 1);
    tick();
    chk("add_done_pc", int'(pc), 1);
    tick();
    chk("hlt_dec_instr", int'(instr), 8'hC0);
    tick();
    chk("hlt_halted", int'(halted), 1);
    chk("hlt_busy", int'(busy), 0);
    chk("hlt_pc", int'(pc), 1);
    chk("hlt_add", int'(add), 0);
    tick();
    chk("hlt_pc_held", int'(pc), 1);
    chk("hlt_still_halted", int'(halted), 1);

    // Restart from HALT, then stall four cycles in DECODE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", int'(pc), int'(INIT_PC));
    chk("restart_busy", int'(busy), 1);
    chk("restart_halted", int'(halted), 0);
    tick();
    chk("stall_pre_instr", int'(instr), 8'h05);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_busy", int'(busy), 1);
      chk("stall_pc", int'(pc), 0);
      chk("stall_instr", int'(instr), 8'h05);
      chk("stall_add_held", int'(add), 0);
    end
    stall   = 1'b0;
    next_pc = 4'h2;
    tick();
    chk("stall_exec_add", int'(add), 1);
    chk("stall_lat6_pc", int'(pc), 0);
    tick();
    chk("stall_lat7_pc", int'(pc), 2);

    // Write attempt during EXEC must be dropped
    tick();
    chk("li_dec_instr", int'(instr), 8'h4A);
    tick();
    chk("li_exec_li", int'(li), 1);
    chk("li_exec_addr", int'(addr), 4'hA);
    load_en   = 1'b1;
    load_addr = 4'h2;
    load_data = 8'hFF;
    tick();
    load_en = 1'b0;
    chk("wr_exec_pc", int'(pc), 2);
    tick();
    chk("wr_exec_readback", int'(instr), 8'h4A);
    tick();
    chk("wr_exec_in_exec", int'(busy), 1);

    // Asynchronous reset in the middle of EXEC
    next_pc = 4'hA;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", int'(pc), int'(INIT_PC));
    chk("arst_busy", int'(busy), 0);
    chk("arst_halted", int'(halted), 0);
    chk("arst_instr", int'(instr), 0);
    tick();
    chk("arst_pc_hold", int'(pc), int'(INIT_PC));

    // Release with start plus a same-cycle write to address 0
    rst_n     = 1'b1;
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 4'h0;
    load_data = 8'h47;
    next_pc   = 4'h3;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    chk("rel_start_busy", int'(busy), 1);
    chk("rel_start_pc", int'(pc), 0);
    tick();
    chk("rel_new_instr", int'(instr), 8'h47);
    tick();
    chk("rel_li", int'(li), 1);
    chk("rel_addr", int'(addr), 7);
    tick();
    chk("br_pc3", int'(pc), 3);
    next_pc = 4'hF;
    tick();
    chk("br_instr", int'(instr), 8'h8F);
    tick();
    chk("br_add", int'(add), 0);
    chk("br_li", int'(li), 0);
    chk("br_addr", int'(addr), 4'hF);
    tick();
    chk("br_pcF", int'(pc), 4'hF);
    next_pc = 4'h0;
    tick();
    chk("br15_instr", int'(instr), 8'h8F);
    tick();
    tick();
    chk("wrap_pc0", int'(pc), 0);
    chk("wrap_busy", int'(busy), 1);

    // Run to HLT with a bounded wait
    next_pc = 4'h1;
    begin
      int budget;
      budget = 20;
      while (!halted && budget > 0) begin
        tick();
        budget--;
      end
      chk("final_halt_reached", int'(halted), 1);
      chk("final_halt_pc", int'(pc), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
